// File: rtl/cp0_core_regs_if.sv
// CP0 register-block bus: MFC0/MTC0 port, exception/ERET commit
// strobes and the state outputs seen by pipeline control.
//  master : pipeline side (drives strobes, reads state)
//  slave  : cp0_core_regs (consumes strobes, drives state)
interface cp0_core_regs_if;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic        exc_bd;
   logic [31:0] exc_pc;
   logic        exc_badv_we;
   logic [31:0] exc_badvaddr;
   logic        eret;
   logic [31:0] epc_out;
   logic [31:0] status_out;
   logic [31:0] cause_out;
   logic        int_req;

   modport master (
      output we, waddr, wdata, raddr,
      output exc_valid, exc_code, exc_bd, exc_pc,
      output exc_badv_we, exc_badvaddr, eret,
      input  rdata, epc_out, status_out, cause_out, int_req
   );

   modport slave (
      input  we, waddr, wdata, raddr,
      input  exc_valid, exc_code, exc_bd, exc_pc,
      input  exc_badv_we, exc_badvaddr, eret,
      output rdata, epc_out, status_out, cause_out, int_req
   );
endinterface

// File: rtl/cp0_core_regs.sv
// MIPS32 CP0 registers: BadVAddr/Count/Compare/Status/Cause/EPC/PRId/Config
// Ports: clk, rst (async high), hw_int[5:0], bus (cp0_core_regs_if.slave)
module cp0_core_regs #(
   parameter int          COUNT_DIV    = 2,
   parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
   parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000,
   parameter int          TIMER_IP     = 5,
   parameter bit          HW_INT_SYNC  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       hw_int,
   cp0_core_regs_if.slave   bus
);

   localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

   logic [31:0]   count;
   logic [31:0]   compare;
   logic [31:0]   epc;
   logic [31:0]   badvaddr;
   logic [PW-1:0] pre;
   logic [7:0]    im;
   logic          exl;
   logic          ie;
   logic          bd;
   logic          ti;
   logic [5:0]    ip_hw;
   logic [1:0]    ip_sw;
   logic [4:0]    exc_code_q;
   logic [5:0]    hw_s;
   logic [5:0]    tmask;
   logic [7:0]    ip;
   logic [31:0]   status;
   logic [31:0]   cause;
   logic [31:0]   count_inc;
   logic          tick;
   logic          wr_count;
   logic          wr_compare;
   logic          ti_hit;

   assign wr_count   = bus.we && (bus.waddr == 5'd9);
   assign wr_compare = bus.we && (bus.waddr == 5'd11);
   assign tick       = (pre == PW'(COUNT_DIV - 1));
   assign count_inc  = count + 32'd1;
   // A Count write on a tick cycle overrides the increment and cannot fire TI.
   assign ti_hit     = tick && !wr_count && (count_inc == compare);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         pre   <= '0;
      end else if (wr_count) begin
         count <= bus.wdata;
         pre   <= '0;
      end else if (tick) begin
         count <= count_inc;
         pre   <= '0;
      end else begin
         pre   <= pre + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         compare <= '0;
         ti      <= 1'b0;
      end else begin
         if (wr_compare)
            compare <= bus.wdata;
         if (wr_compare)
            ti <= 1'b0;
         else if (ti_hit)
            ti <= 1'b1;
      end
   end

   // The IP register itself is the second synchroniser flop.
   generate
      if (HW_INT_SYNC) begin : g_sync
         logic [5:0] hw_s1;
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               hw_s1 <= '0;
            else
               hw_s1 <= hw_int;
         end
         assign hw_s = hw_s1;
      end else begin : g_nosync
         assign hw_s = hw_int;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ip_hw <= '0;
      else
         ip_hw <= hw_s;
   end

   // TI is merged combinationally so IP follows TI in the same cycle.
   always_comb begin
      tmask           = '0;
      tmask[TIMER_IP] = ti;
   end

   assign ip = {ip_hw | tmask, ip_sw};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         im         <= '0;
         exl        <= 1'b0;
         ie         <= 1'b0;
         bd         <= 1'b0;
         ip_sw      <= '0;
         exc_code_q <= '0;
         epc        <= '0;
         badvaddr   <= '0;
      end else if (bus.exc_valid) begin
         exc_code_q <= bus.exc_code;
         exl        <= 1'b1;
         if (!exl) begin
            epc <= bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
            bd  <= bus.exc_bd;
         end
         if (bus.exc_badv_we)
            badvaddr <= bus.exc_badvaddr;
      end else if (bus.eret) begin
         exl <= 1'b0;
      end else if (bus.we) begin
         case (bus.waddr)
            5'd12: begin
               im  <= bus.wdata[15:8];
               exl <= bus.wdata[1];
               ie  <= bus.wdata[0];
            end
            5'd13: ip_sw <= bus.wdata[9:8];
            5'd14: epc   <= bus.wdata;
            default: ;
         endcase
      end
   end

   assign status = {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
   assign cause  = {bd, ti, 14'b0, ip, 1'b0, exc_code_q, 2'b0};

   always_comb begin
      case (bus.raddr)
         5'd8:    bus.rdata = badvaddr;
         5'd9:    bus.rdata = count;
         5'd11:   bus.rdata = compare;
         5'd12:   bus.rdata = status;
         5'd13:   bus.rdata = cause;
         5'd14:   bus.rdata = epc;
         5'd15:   bus.rdata = PRID_VALUE;
         5'd16:   bus.rdata = CONFIG_VALUE;
         default: bus.rdata = '0;
      endcase
   end

   assign bus.epc_out    = epc;
   assign bus.status_out = status;
   assign bus.cause_out  = cause;
   assign bus.int_req    = ie & ~exl & (|(ip & im));

endmodule
